uart_tx_frame: RTL and testbench

Parametrised UART transmitter. It serialises one data word per accepted request into an asynchronous serial frame: start bit, 5–8 data bits LSB-first, an optional parity bit, and 1 or 2 stop bits. The bit period is set by a clock divider. It sits between the design's byte producers and the board TX pin. A valid/ready handshake allows back-to-back frames with no idle gap, and a one-cycle done pulse marks the end of each frame.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx_frame.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path (and the future receiver).
//   tx_state_t           : transmitter frame state
//   DEFAULT_CLKS_PER_BIT : 100 MHz system clock / 9600 baud
//   PAR_EVEN / PAR_ODD   : parity-select values for the PARITY_ODD parameter
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10416;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period with tick; the counter wraps to 0 on every tick.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clear  : restart the bit period (takes priority over enable)
//   enable : count while high; tick is suppressed while low
//   tick   : high on the final cycle of a bit period (combinational)
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity
// bit, STOP_BITS stop bits. A valid/ready handshake allows back-to-back frames
// with no idle gap; done pulses for one cycle after each frame.
//
// Build option: define UART_TX_PARITY_EN to include the parity bit
// (PARITY_ODD then selects odd (1) or even (0) parity).
//
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   valid : request to send data
//   data  : word to send, sampled only on acceptance (valid && ready)
//   ready : can accept a word this cycle (combinational)
//   dout  : serial line, idle high (registered)
//   busy  : frame in progress (registered)
//   done  : one-cycle pulse after the final stop bit (registered)
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = PAR_EVEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 dout,
    output logic                 busy,
    output logic                 done
);

    localparam int BIT_W = $clog2(DATA_BITS);

    // Reject illegal configurations at elaboration time.
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD)) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter combination");
    end

    tx_state_t            state, state_next;
    logic                 tick;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;
    logic                 frame_end;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 dout_next;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .enable(state != IDLE),
        .tick  (tick)
    );

    assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign frame_end = (state == STOP) && last_stop && tick;
    // Ready also on the last stop cycle, so a waiting word starts with no gap.
    assign ready     = (state == IDLE) || frame_end;
    assign accept    = valid && ready;

    // Shift register advances only when a data bit finishes.
    assign shift_next = accept                       ? data :
                        (state == DATA && tick)      ? (shift >> 1) :
                                                       shift;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dout  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            dout  <= dout_next;
            busy  <= (state_next != IDLE);
            done  <= frame_end;
        end
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = START;
            START: if (tick)   state_next = DATA;
            DATA: if (tick && last_data) begin
`ifdef UART_TX_PARITY_EN
                state_next = PARITY;
`else
                state_next = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_next = STOP;
`endif
            STOP:  if (frame_end) state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: the line level for the state being entered, registered
    // above so dout changes on the same edge as the state.
    always_comb begin
        dout_next = 1'b1;
        case (state_next)
            START:  dout_next = 1'b0;
            DATA:   dout_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY: dout_next = par_q;
`endif
            default: dout_next = 1'b1;
        endcase
    end

    // Datapath: shift register, bit counters, parity of the accepted word.
    // NOTE: the shift register is reset too; it is a handful of flops and a
    // known value keeps dout deterministic straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            shift <= shift_next;
            if (state == DATA && tick) begin
                bit_cnt <= last_data ? '0 : bit_cnt + BIT_W'(1);
            end
            if (state == STOP && tick) begin
                stop_cnt <= last_stop ? 1'b0 : 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            if (accept) begin
                par_q <= (^data) ^ 1'(PARITY_ODD);
            end
`endif
        end
    end

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame with CLKS_PER_BIT = 4. Three instances:
//   unit 0 : 8 data bits, 1 stop, even parity
//   unit 1 : 8 data bits, 1 stop, odd parity (exercised with UART_TX_PARITY_EN)
//   unit 2 : 5 data bits, 2 stop, even parity
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected line patterns are written with bit i = i-th bit on the line.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int N = 4;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    // start, data LSB-first, parity, stop
    localparam logic [15:0] EXP_A5  = 16'h054A; // 0 10100101 0 1
    localparam logic [15:0] EXP_55  = 16'h04AA; // 0 10101010 0 1
    localparam logic [15:0] EXP_AA  = 16'h0554; // 0 01010101 0 1
    localparam logic [15:0] EXP_3C  = 16'h0478; // 0 00111100 0 1
    localparam logic [15:0] EXP_1F  = 16'h01FE; // 0 11111 1 1 1
    localparam logic [15:0] EXP_07E = 16'h060E; // 0 11100000 1 1
    localparam logic [15:0] EXP_07O = 16'h040E; // 0 11100000 0 1
`else
    localparam int P = 0;
    localparam logic [15:0] EXP_A5  = 16'h034A; // 0 10100101 1
    localparam logic [15:0] EXP_55  = 16'h02AA; // 0 10101010 1
    localparam logic [15:0] EXP_AA  = 16'h0354; // 0 01010101 1
    localparam logic [15:0] EXP_3C  = 16'h0278; // 0 00111100 1
    localparam logic [15:0] EXP_1F  = 16'h00FE; // 0 11111 1 1
`endif
    localparam int NB8 = 10 + P;
    localparam int NB5 = 8 + P;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] valid_v;
    logic [7:0] data_v [3];
    wire  [2:0] dout_v, ready_v, busy_v, done_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(N), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PAR_EVEN)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid_v[0]), .data(data_v[0]),
        .ready(ready_v[0]), .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    uart_tx_frame #(.CLKS_PER_BIT(N), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PAR_ODD)) dut_odd (
        .clk(clk), .rst_n(rst_n), .valid(valid_v[1]), .data(data_v[1]),
        .ready(ready_v[1]), .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    uart_tx_frame #(.CLKS_PER_BIT(N), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(PAR_EVEN)) dut_5n2 (
        .clk(clk), .rst_n(rst_n), .valid(valid_v[2]), .data(data_v[2][4:0]),
        .ready(ready_v[2]), .dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word at the current falling edge; it is accepted on the next
    // rising edge. Returns at the falling edge just after acceptance.
    task automatic send(input int u, input logic [7:0] w, input string tag);
        valid_v[u] = 1'b1;
        data_v[u]  = w;
        check($sformatf("%s ready before accept", tag), 32'(ready_v[u]), 32'd1);
        @(negedge clk);
    endtask

    // Check nb line bits, each held N cycles, starting at the current falling
    // edge (cycle 0 = first cycle after the accept edge).
    task automatic expect_line(input int u, input logic [15:0] bits, input int nb,
                               input int drop_at, input string tag);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = b * N + k;
                if (c == drop_at) valid_v[u] = 1'b0;
                check($sformatf("%s c%0d dout", tag, c), 32'(dout_v[u]), 32'(bits[b]));
                check($sformatf("%s c%0d busy", tag, c), 32'(busy_v[u]), 32'd1);
                check($sformatf("%s c%0d ready", tag, c), 32'(ready_v[u]),
                      32'((b == nb - 1) && (k == N - 1)));
                if (c != 0)
                    check($sformatf("%s c%0d done", tag, c), 32'(done_v[u]), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    // Idle frame end: done pulses for exactly one cycle, line back to idle.
    task automatic expect_end(input int u, input string tag);
        check($sformatf("%s end done", tag),  32'(done_v[u]),  32'd1);
        check($sformatf("%s end dout", tag),  32'(dout_v[u]),  32'd1);
        check($sformatf("%s end busy", tag),  32'(busy_v[u]),  32'd0);
        check($sformatf("%s end ready", tag), 32'(ready_v[u]), 32'd1);
        @(negedge clk);
        check($sformatf("%s done drop", tag), 32'(done_v[u]),  32'd0);
    endtask

    initial begin
        rst_n   = 1'b1;
        valid_v = '0;
        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
        #1 rst_n = 1'b0;

        // Reset state, observed while reset is held.
        #11;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst u%0d dout", u),  32'(dout_v[u]),  32'd1);
            check($sformatf("rst u%0d ready", u), 32'(ready_v[u]), 32'd1);
            check($sformatf("rst u%0d busy", u),  32'(busy_v[u]),  32'd0);
            check($sformatf("rst u%0d done", u),  32'(done_v[u]),  32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst dout", 32'(dout_v[0]), 32'd1);
        check("post-rst busy", 32'(busy_v[0]), 32'd0);

        // Single frame.
        send(0, 8'hA5, "A5");
        expect_line(0, EXP_A5, NB8, 0, "A5");
        expect_end(0, "A5");

`ifdef UART_TX_PARITY_EN
        // Parity bit: 0x07 has three ones.
        send(0, 8'h07, "07E");
        expect_line(0, EXP_07E, NB8, 0, "07E");
        expect_end(0, "07E");
        send(1, 8'h07, "07O");
        expect_line(1, EXP_07O, NB8, 0, "07O");
        expect_end(1, "07O");
`endif

        // Back-to-back: valid held, second word queued during the first frame.
        send(0, 8'h55, "S55");
        data_v[0] = 8'hAA;
        expect_line(0, EXP_55, NB8, -1, "S55");
        check("S55 done at next start", 32'(done_v[0]), 32'd1);
        expect_line(0, EXP_AA, NB8, 0, "SAA");
        expect_end(0, "SAA");

        // Reset in the middle of data bit 3 (line bit 4, a 0 for 0xA5).
        send(0, 8'hA5, "R");
        valid_v[0] = 1'b0;
        repeat (4 * N + 1) @(negedge clk);
        check("R dout before reset", 32'(dout_v[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("R dout in reset", 32'(dout_v[0]),  32'd1);
        check("R busy in reset", 32'(busy_v[0]),  32'd0);
        check("R ready in reset", 32'(ready_v[0]), 32'd1);
        @(negedge clk);
        check("R still idle", 32'(dout_v[0]), 32'd1);
        // Release and present the next word on the same falling edge, so it is
        // accepted on the first rising edge after release.
        rst_n = 1'b1;
        send(0, 8'h3C, "3C");
        expect_line(0, EXP_3C, NB8, 0, "3C");
        expect_end(0, "3C");

        // 5 data bits, 2 stop bits; data and valid wiggle mid-frame.
        send(2, 8'h1F, "5N2");
        data_v[2] = 8'h00;
        expect_line(2, EXP_1F, NB5, 10, "5N2");
        expect_end(2, "5N2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx_frame
